// File: rtl/einstein_mem_arbiter_if.sv
// rtl/einstein_mem_arbiter_if.sv - CPU, download and SDRAM signal bundle for the Einstein memory arbiter
interface einstein_mem_arbiter_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [14:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_ram_rd;
    logic        cpu_ram_wr;
    logic        cpu_roma_rd;
    logic        cpu_romb_rd;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;

    logic [22:0] sdram_addr;
    logic [7:0]  sdram_din;
    logic        sdram_rd;
    logic        sdram_we;
    logic [7:0]  sdram_dout;
    logic        sdram_ready;

    logic        err_overflow;
    logic        err_timeout;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  cpu_addr, cpu_din, cpu_ram_rd, cpu_ram_wr, cpu_roma_rd, cpu_romb_rd,
        output cpu_dout, cpu_wait,
        output sdram_addr, sdram_din, sdram_rd, sdram_we,
        input  sdram_dout, sdram_ready,
        output err_overflow, err_timeout
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output cpu_addr, cpu_din, cpu_ram_rd, cpu_ram_wr, cpu_roma_rd, cpu_romb_rd,
        input  cpu_dout, cpu_wait,
        input  sdram_addr, sdram_din, sdram_rd, sdram_we,
        output sdram_dout, sdram_ready,
        input  err_overflow, err_timeout
    );
endinterface

// File: rtl/einstein_mem_arbiter.sv
// rtl/einstein_mem_arbiter.sv - registered arbiter of CPU strobes and ROM download onto the byte SDRAM port
module einstein_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    einstein_mem_arbiter_if.slave  bus
);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, CPU_RD, CPU_WR, IO_WR, DONE} state_e;

    state_e      state_q;
    logic [7:0]  timer_q;
    logic        strobe_dly_q;
    logic        pend_valid_q;
    logic [14:0] pend_addr_q;
    logic [7:0]  pend_data_q;
    logic        defer_q;
    logic        defer_we_q;
    logic [22:0] defer_addr_q;
    logic [7:0]  defer_data_q;
    logic [22:0] sdram_addr_q;
    logic [7:0]  sdram_din_q;
    logic        sdram_rd_q;
    logic        sdram_we_q;
    logic [7:0]  cpu_dout_q;
    logic        cpu_wait_q;
    logic        err_overflow_q;
    logic        err_timeout_q;

    logic        strobe_any;
    logic        cpu_edge;
    logic        req_we;
    logic [22:0] req_addr;
    logic        pend_take;
    logic        direct_issue;
    logic        iss_go;
    state_e      iss_state;
    logic [22:0] iss_addr;
    logic [7:0]  iss_din;

    assign strobe_any   = bus.cpu_ram_rd | bus.cpu_ram_wr | bus.cpu_roma_rd | bus.cpu_romb_rd;
    assign cpu_edge     = strobe_any & ~strobe_dly_q & ~bus.ioctl_download;
    assign pend_take    = (state_q == IDLE) && pend_valid_q;
    // An edge is served straight away only when nothing else is queued ahead of it.
    assign direct_issue = (state_q == IDLE) && !pend_valid_q && !defer_q;

    always_comb begin
        req_we   = 1'b0;
        req_addr = 23'h000000;
        if (bus.cpu_ram_wr) begin
            req_we   = 1'b1;
            req_addr = 23'h010000 + {7'h00, bus.cpu_addr};
        end else if (bus.cpu_ram_rd) begin
            req_addr = 23'h010000 + {7'h00, bus.cpu_addr};
        end else if (bus.cpu_roma_rd) begin
            req_addr = {9'h000, bus.cpu_addr[13:0]};
        end else begin
            req_addr = 23'h004000 + {9'h000, bus.cpu_addr[13:0]};
        end
    end

    always_comb begin
        iss_go    = 1'b0;
        iss_state = IDLE;
        iss_addr  = 23'h000000;
        iss_din   = 8'h00;
        if (pend_valid_q) begin
            iss_go    = 1'b1;
            iss_state = IO_WR;
            iss_addr  = {8'h00, pend_addr_q};
            iss_din   = pend_data_q;
        end else if (defer_q && !bus.ioctl_download) begin
            iss_go    = 1'b1;
            iss_state = defer_we_q ? CPU_WR : CPU_RD;
            iss_addr  = defer_addr_q;
            iss_din   = defer_data_q;
        end else if (cpu_edge) begin
            iss_go    = 1'b1;
            iss_state = req_we ? CPU_WR : CPU_RD;
            iss_addr  = req_addr;
            iss_din   = bus.cpu_din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= 8'h00;
            strobe_dly_q   <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_addr_q    <= 15'h0000;
            pend_data_q    <= 8'h00;
            defer_q        <= 1'b0;
            defer_we_q     <= 1'b0;
            defer_addr_q   <= 23'h000000;
            defer_data_q   <= 8'h00;
            sdram_addr_q   <= 23'h000000;
            sdram_din_q    <= 8'h00;
            sdram_rd_q     <= 1'b0;
            sdram_we_q     <= 1'b0;
            cpu_dout_q     <= 8'hFF;
            cpu_wait_q     <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            strobe_dly_q <= strobe_any;

            if (bus.ioctl_wr) begin
                pend_valid_q <= 1'b1;
                pend_addr_q  <= bus.ioctl_addr;
                pend_data_q  <= bus.ioctl_dout;
                if (pend_valid_q && !pend_take) begin
                    err_overflow_q <= 1'b1;
                end
            end else if (pend_take) begin
                pend_valid_q <= 1'b0;
            end

            if (bus.ioctl_download) begin
                defer_q <= 1'b0;
            end else if (cpu_edge && !direct_issue) begin
                defer_q      <= 1'b1;
                defer_we_q   <= req_we;
                defer_addr_q <= req_addr;
                defer_data_q <= bus.cpu_din;
            end else if ((state_q == IDLE) && !pend_valid_q && defer_q) begin
                defer_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (iss_go) begin
                        state_q      <= iss_state;
                        timer_q      <= 8'h00;
                        sdram_addr_q <= iss_addr;
                        sdram_din_q  <= iss_din;
                        sdram_rd_q   <= (iss_state == CPU_RD);
                        sdram_we_q   <= (iss_state != CPU_RD);
                        cpu_wait_q   <= (iss_state != IO_WR);
                    end
                end
                CPU_RD, CPU_WR, IO_WR: begin
                    if (bus.sdram_ready) begin
                        state_q    <= DONE;
                        sdram_rd_q <= 1'b0;
                        sdram_we_q <= 1'b0;
                        cpu_wait_q <= 1'b0;
                        if (state_q == CPU_RD) begin
                            cpu_dout_q <= bus.sdram_dout;
                        end
                    end else if (timer_q == TIMEOUT_C) begin
                        state_q       <= DONE;
                        sdram_rd_q    <= 1'b0;
                        sdram_we_q    <= 1'b0;
                        cpu_wait_q    <= 1'b0;
                        err_timeout_q <= 1'b1;
                        if (state_q == CPU_RD) begin
                            cpu_dout_q <= 8'hFF;
                        end
                    end else begin
                        timer_q <= timer_q + 8'h01;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sdram_addr   = sdram_addr_q;
    assign bus.sdram_din    = sdram_din_q;
    assign bus.sdram_rd     = sdram_rd_q;
    assign bus.sdram_we     = sdram_we_q;
    assign bus.cpu_dout     = cpu_dout_q;
    assign bus.cpu_wait     = cpu_wait_q;
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_timeout  = err_timeout_q;
endmodule

// File: tb/tb_einstein_mem_arbiter.sv
// tb/tb_einstein_mem_arbiter.sv - directed self-checking bench for einstein_mem_arbiter
module tb_einstein_mem_arbiter;
    logic clk_sys;
    logic reset;
    int   n_assert;
    int   n_fail;

    einstein_mem_arbiter_if bus ();

    einstein_mem_arbiter #(.TIMEOUT(255)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(negedge clk_sys);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [14:0] a;
        logic [7:0]  d;
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 15'h0000;
        bus.ioctl_dout     = 8'h00;
        bus.cpu_addr       = 16'h0000;
        bus.cpu_din        = 8'h00;
        bus.cpu_ram_rd     = 1'b0;
        bus.cpu_ram_wr     = 1'b0;
        bus.cpu_roma_rd    = 1'b0;
        bus.cpu_romb_rd    = 1'b0;
        bus.sdram_dout     = 8'h00;
        bus.sdram_ready    = 1'b0;
        step();
        step();
        reset = 1'b0;

        check("rst_rd",   32'(bus.sdram_rd), 32'h0);
        check("rst_we",   32'(bus.sdram_we), 32'h0);
        check("rst_addr", 32'(bus.sdram_addr), 32'h0);
        check("rst_din",  32'(bus.sdram_din), 32'h0);
        check("rst_dout", 32'(bus.cpu_dout), 32'hFF);
        check("rst_wait", 32'(bus.cpu_wait), 32'h0);
        check("rst_errs", 32'({bus.err_overflow, bus.err_timeout}), 32'h0);

        // RAM read, ready five cycles after the edge
        bus.cpu_addr   = 16'h1234;
        bus.cpu_ram_rd = 1'b1;
        step();
        check("ram_rd_req",  32'(bus.sdram_rd), 32'h1);
        check("ram_rd_addr", 32'(bus.sdram_addr), 32'h011234);
        check("ram_rd_wait", 32'(bus.cpu_wait), 32'h1);
        step(); step(); step();
        check("ram_rd_held", 32'(bus.sdram_rd), 32'h1);
        step();
        bus.sdram_dout  = 8'hA5;
        bus.sdram_ready = 1'b1;
        check("ram_rd_held5", 32'(bus.sdram_rd), 32'h1);
        step();
        bus.sdram_ready = 1'b0;
        check("ram_rd_drop", 32'(bus.sdram_rd), 32'h0);
        check("ram_rd_dout", 32'(bus.cpu_dout), 32'hA5);
        check("ram_rd_wait_low", 32'(bus.cpu_wait), 32'h0);
        bus.cpu_ram_rd = 1'b0;
        step(); step();

        // ROMA beats ROMB on a shared edge; ROMB alone maps above 0x4000
        bus.cpu_addr    = 16'h7FFF;
        bus.cpu_roma_rd = 1'b1;
        bus.cpu_romb_rd = 1'b1;
        step();
        check("roma_addr", 32'(bus.sdram_addr), 32'h003FFF);
        check("roma_rd",   32'(bus.sdram_rd), 32'h1);
        bus.sdram_dout  = 8'h11;
        bus.sdram_ready = 1'b1;
        step();
        bus.sdram_ready = 1'b0;
        check("roma_dout", 32'(bus.cpu_dout), 32'h11);
        step(); step(); step();
        check("roma_single", 32'({bus.sdram_rd, bus.sdram_we}), 32'h0);
        bus.cpu_roma_rd = 1'b0;
        bus.cpu_romb_rd = 1'b0;
        step();
        bus.cpu_romb_rd = 1'b1;
        step();
        check("romb_addr", 32'(bus.sdram_addr), 32'h007FFF);
        check("romb_rd",   32'(bus.sdram_rd), 32'h1);
        bus.sdram_dout  = 8'h22;
        bus.sdram_ready = 1'b1;
        step();
        bus.sdram_ready = 1'b0;
        bus.cpu_romb_rd = 1'b0;
        check("romb_dout", 32'(bus.cpu_dout), 32'h22);
        step(); step();

        // RAM write wins over a simultaneous RAM read
        bus.cpu_addr   = 16'hFFFF;
        bus.cpu_din    = 8'h5A;
        bus.cpu_ram_wr = 1'b1;
        bus.cpu_ram_rd = 1'b1;
        step();
        check("wr_prio", 32'({bus.sdram_we, bus.sdram_rd}), 32'h2);
        check("wr_addr", 32'(bus.sdram_addr), 32'h01FFFF);
        check("wr_din",  32'(bus.sdram_din), 32'h5A);
        check("wr_wait", 32'(bus.cpu_wait), 32'h1);
        bus.sdram_ready = 1'b1;
        step();
        bus.sdram_ready = 1'b0;
        bus.cpu_ram_wr  = 1'b0;
        bus.cpu_ram_rd  = 1'b0;
        check("wr_drop", 32'(bus.sdram_we), 32'h0);
        check("wr_keeps_dout", 32'(bus.cpu_dout), 32'h22);
        step(); step();

        // Pending download byte goes first; the CPU edge is deferred
        bus.ioctl_addr = 15'h0010;
        bus.ioctl_dout = 8'h77;
        bus.ioctl_wr   = 1'b1;
        step();
        bus.ioctl_wr   = 1'b0;
        bus.cpu_addr   = 16'h0200;
        bus.cpu_ram_rd = 1'b1;
        step();
        check("defer_io_we",   32'({bus.sdram_we, bus.sdram_rd}), 32'h2);
        check("defer_io_addr", 32'(bus.sdram_addr), 32'h000010);
        check("defer_io_din",  32'(bus.sdram_din), 32'h77);
        check("defer_io_wait", 32'(bus.cpu_wait), 32'h0);
        bus.sdram_ready = 1'b1;
        step();
        bus.sdram_ready = 1'b0;
        bus.cpu_ram_rd  = 1'b0;
        check("defer_io_drop", 32'(bus.sdram_we), 32'h0);
        step();
        check("defer_gap", 32'(bus.sdram_rd), 32'h0);
        step();
        check("defer_rd",   32'(bus.sdram_rd), 32'h1);
        check("defer_addr", 32'(bus.sdram_addr), 32'h010200);
        check("defer_wait", 32'(bus.cpu_wait), 32'h1);
        bus.sdram_dout  = 8'h3C;
        bus.sdram_ready = 1'b1;
        step();
        bus.sdram_ready = 1'b0;
        check("defer_dout", 32'(bus.cpu_dout), 32'h3C);
        check("defer_no_ovf", 32'(bus.err_overflow), 32'h0);
        step(); step();

        // Download stream at one write per four cycles, low and high ends of the range
        bus.ioctl_download = 1'b1;
        for (int k = 0; k < 64; k++) begin
            a = (k < 32) ? 15'(k) : 15'(32'h7FE0 + k - 32);
            d = a[7:0] ^ 8'h5A;
            bus.ioctl_addr = a;
            bus.ioctl_dout = d;
            bus.ioctl_wr   = 1'b1;
            step();
            bus.ioctl_wr   = 1'b0;
            step();
            check("dl_we_addr", 32'({bus.sdram_we, bus.sdram_addr}), 32'({1'b1, 8'h00, a}));
            check("dl_din", 32'(bus.sdram_din), 32'(d));
            step();
            bus.sdram_ready = 1'b1;
            step();
            bus.sdram_ready = 1'b0;
            check("dl_drop", 32'(bus.sdram_we), 32'h0);
        end
        check("dl_no_ovf", 32'(bus.err_overflow), 32'h0);

        // Overflow: two more bytes arrive while the first write is stalled
        bus.ioctl_addr = 15'h0100;
        bus.ioctl_dout = 8'h01;
        bus.ioctl_wr   = 1'b1;
        step();
        bus.ioctl_wr   = 1'b0;
        step();
        check("ovf_first", 32'({bus.sdram_we, bus.sdram_addr}), 32'({1'b1, 23'h000100}));
        step();
        bus.ioctl_addr = 15'h0101;
        bus.ioctl_dout = 8'h02;
        bus.ioctl_wr   = 1'b1;
        step();
        bus.ioctl_wr   = 1'b0;
        step();
        bus.ioctl_addr = 15'h0102;
        bus.ioctl_dout = 8'h03;
        bus.ioctl_wr   = 1'b1;
        step();
        bus.ioctl_wr   = 1'b0;
        check("ovf_flag", 32'(bus.err_overflow), 32'h1);
        check("ovf_first_held", 32'({bus.sdram_we, bus.sdram_addr}), 32'({1'b1, 23'h000100}));
        repeat (16) step();
        bus.sdram_ready = 1'b1;
        step();
        bus.sdram_ready = 1'b0;
        check("ovf_first_drop", 32'(bus.sdram_we), 32'h0);
        step();
        check("ovf_gap", 32'(bus.sdram_we), 32'h0);
        step();
        check("ovf_second", 32'({bus.sdram_we, bus.sdram_addr}), 32'({1'b1, 23'h000102}));
        check("ovf_second_din", 32'(bus.sdram_din), 32'h03);
        bus.sdram_ready = 1'b1;
        step();
        bus.sdram_ready = 1'b0;
        step(); step(); step();
        check("ovf_no_third", 32'(bus.sdram_we), 32'h0);
        bus.ioctl_download = 1'b0;
        step();

        // Timeout: read never answered
        bus.cpu_addr   = 16'h0042;
        bus.cpu_ram_rd = 1'b1;
        step();
        check("to_issue", 32'({bus.sdram_rd, bus.sdram_addr}), 32'({1'b1, 23'h010042}));
        repeat (255) step();
        check("to_last_busy", 32'(bus.sdram_rd), 32'h1);
        step();
        check("to_drop", 32'(bus.sdram_rd), 32'h0);
        check("to_dout", 32'(bus.cpu_dout), 32'hFF);
        check("to_flag", 32'(bus.err_timeout), 32'h1);
        check("to_wait", 32'(bus.cpu_wait), 32'h0);
        check("ovf_sticky", 32'(bus.err_overflow), 32'h1);
        bus.cpu_ram_rd = 1'b0;
        step(); step();
        bus.cpu_addr   = 16'h0043;
        bus.cpu_ram_rd = 1'b1;
        step();
        check("post_to_rd", 32'(bus.sdram_rd), 32'h1);
        bus.sdram_dout  = 8'h5C;
        bus.sdram_ready = 1'b1;
        step();
        bus.sdram_ready = 1'b0;
        bus.cpu_ram_rd  = 1'b0;
        check("post_to_dout", 32'(bus.cpu_dout), 32'h5C);
        check("to_sticky", 32'(bus.err_timeout), 32'h1);
        step(); step();

        // Reset during a CPU write
        bus.cpu_addr   = 16'h1000;
        bus.cpu_din    = 8'hC3;
        bus.cpu_ram_wr = 1'b1;
        step();
        check("rw_issue", 32'(bus.sdram_we), 32'h1);
        reset          = 1'b1;
        bus.cpu_ram_wr = 1'b0;
        step();
        reset = 1'b0;
        check("rw_we",    32'(bus.sdram_we), 32'h0);
        check("rw_wait",  32'(bus.cpu_wait), 32'h0);
        check("rw_flags", 32'({bus.err_overflow, bus.err_timeout}), 32'h0);
        check("rw_dout",  32'(bus.cpu_dout), 32'hFF);
        check("rw_addr",  32'(bus.sdram_addr), 32'h0);
        step(); step();
        check("rw_no_req", 32'({bus.sdram_rd, bus.sdram_we}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/einstein_mem_arbiter.md
# einstein_mem_arbiter

Registered request arbiter between the Einstein machine's memory strobes (CPU RAM/ROM/diagnostic-ROM reads and writes), the ROM download port, and the byte-wide SDRAM controller. It sits directly upstream of the SDRAM controller in clk_sys. It replaces the combinational address/strobe mux with edge-detected, held requests and a latched read-data register. It adds a one-deep download write buffer, a request watchdog and sticky error flags.

## Interface
- `TIMEOUT`, 255: clk_sys cycles allowed between request issue and `sdram_ready` before abort (8-bit counter).
- `clk_sys` in 1: system clock, 32 MHz.
- `reset` in 1: synchronous, active-high.
- `ioctl_download` in 1: download in progress; CPU requests ignored while high.
- `ioctl_wr` in 1: one-cycle download write strobe.
- `ioctl_addr` in 15: download byte address.
- `ioctl_dout` in 8: download byte.
- `cpu_addr` in 16: CPU memory address.
- `cpu_din` in 8: CPU write data.
- `cpu_ram_rd`, `cpu_ram_wr`, `cpu_roma_rd`, `cpu_romb_rd` in 1 each: level strobes, held ≥2 clk_sys.
- `cpu_dout` out 8: latched read data.
- `cpu_wait` out 1: CPU access in flight.
- `sdram_addr` out 23: registered SDRAM byte address.
- `sdram_din` out 8: registered write data.
- `sdram_rd`, `sdram_we` out 1: held request.
- `sdram_dout` in 8: SDRAM read data, valid in the cycle `sdram_ready`=1.
- `sdram_ready` in 1: one-cycle completion pulse.
- `err_overflow`, `err_timeout` out 1: sticky error flags, cleared only by reset.

## Operation
- Address map (23-bit):
  - download: 0x000000 + `ioctl_addr[14:0]`
  - ROMA: 0x000000 + `cpu_addr[13:0]`
  - ROMB: 0x004000 + `cpu_addr[13:0]`
  - RAM: 0x010000 + `cpu_addr[15:0]`
- Edge detect: a request is the rising edge of the OR of the four CPU strobes, using a one-cycle delayed copy.
- Simultaneous strobes resolve by priority ram_wr > ram_rd > roma_rd > romb_rd. Only one access is issued per rising edge.
- Download buffer: `ioctl_wr` loads the pending register (addr, data, valid=1) regardless of state. If valid is already 1 when `ioctl_wr` arrives, the new byte overwrites it and `err_overflow` is set.
- FSM states:
  - IDLE:
    - pending valid → IO_WR; loads addr/din and clears valid in the same cycle (an `ioctl_wr` in that same cycle sets valid, with no overflow).
    - else CPU edge and !`ioctl_download` → CPU_RD or CPU_WR.
    - Pending download takes priority over a simultaneous CPU edge. That CPU edge is recorded as deferred and served on the next IDLE.
  - CPU_RD: `sdram_rd`=1 held with stable addr. On `sdram_ready`, latch `sdram_dout` into `cpu_dout` → DONE.
  - CPU_WR, IO_WR: `sdram_we`=1 held with stable addr/din. On `sdram_ready` → DONE.
  - DONE: one idle cycle, then IDLE.
  - Any busy state: timeout counter reaches `TIMEOUT` without ready → set `err_timeout`. In CPU_RD, `cpu_dout` is set to 0xFF. → DONE.
- Download rising mid-access: the in-flight access completes normally. Deferred or new CPU edges are discarded while `ioctl_download`=1.
- `cpu_dout` holds its value until the next CPU read completes. Writes do not alter it.

## Timing
- Reset values: state IDLE, `sdram_rd`=`sdram_we`=0, `sdram_addr`=0, `sdram_din`=0, `cpu_dout`=0xFF, `cpu_wait`=0, pending valid=0, deferred=0, both error flags 0, strobe delay=0.
- Reset asserted mid-access drops the request in the next cycle. All state returns to reset values and no pending or deferred work survives.
- CPU edge detected in cycle N (IDLE): `sdram_rd`/`sdram_we` and `cpu_wait` high from N+1.
- `sdram_ready` in cycle M:
  - request low from M+1
  - `cpu_dout` valid from M+1
  - `cpu_wait` low from M+1
  - earliest next request issued M+3
- `ioctl_wr` in cycle N with arbiter IDLE: `sdram_we` high from N+2 (buffer load, then issue).
- Timeout: the counter starts at 0 on the issue cycle and increments each busy cycle without ready. Abort happens in the cycle it equals `TIMEOUT`, and the request is low the next cycle.
- Outputs are all registered. No combinational path from inputs to outputs.

## Test plan
- RAM read: `cpu_addr`=0x1234, `cpu_ram_rd` rises at N, ready at N+5 with 0xA5 → `sdram_addr`=0x011234, `sdram_rd`=1 over N+1..N+5, `cpu_dout`=0xA5 and `cpu_wait`=0 at N+6.
- Priority and map:
  - `cpu_roma_rd` and `cpu_romb_rd` rise together at `cpu_addr`=0x7FFF → single read at 0x003FFF.
  - Then `cpu_romb_rd` alone rising → 0x007FFF.
- Download stream: `ioctl_wr` every 4 cycles, ready 1 cycle after issue, addr 0..0x7FFF → 32768 writes, addresses 0x000000..0x007FFF in order, `err_overflow`=0.
- Overflow: ready withheld for 20 cycles while `ioctl_wr` pulses twice → `err_overflow`=1. Only the second byte is written after the first completes.
- Timeout: RAM read with `sdram_ready` never asserted → `sdram_rd` drops after 256 busy cycles, `cpu_dout`=0xFF, `err_timeout`=1. Next read with ready proceeds normally.
- Reset mid-write: `reset` for one cycle during CPU_WR → next cycle `sdram_we`=0, `cpu_wait`=0, flags 0, `cpu_dout`=0xFF.
